// File: rtl/systolic_mm_nxn.sv
// NxN output-stationary systolic matrix multiplier (C = A x B) with valid/ready in and out.
// Define SYSTOLIC_SIGNED_EN for two's-complement operands; default build is unsigned.
module systolic_mm_nxn #(
    parameter int N  = 3,
    parameter int DW = 2,
    parameter int AW = 2*DW + $clog2(N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*DW-1:0]        a_col,
    input  logic [N*DW-1:0]        b_row,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AW-1:0]          out_data,
    output logic [$clog2(N)-1:0]   out_row,
    output logic [$clog2(N)-1:0]   out_col,
    output logic                   out_last,
    output logic                   busy
);
    localparam int RW  = $clog2(N);
    localparam int DCW = $clog2(2*N+1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;
    state_t state;

    logic [RW-1:0]  beat_cnt;
    logic [DCW-1:0] drain_cnt;
    logic           accept;
    logic           start;
    logic [DW-1:0]  a_skew [N];
    logic [DW-1:0]  b_skew [N];
    logic [DW-1:0]  a_pe   [N][N];
    logic [DW-1:0]  b_pe   [N][N];
    logic [AW-1:0]  acc    [N][N];
    logic [AW-1:0]  out_buf[N][N];
    logic [RW-1:0]  row_next;
    logic [RW-1:0]  col_next;

    assign in_ready = (state == IDLE) || (state == LOAD);
    assign accept   = in_valid && in_ready;
    assign start    = accept && (state == IDLE);

    // Input register plus i extra stages for row/column i; idle cycles inject zeros.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic [DW-1:0] a_sr [gi+1];
        logic [DW-1:0] b_sr [gi+1];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int s = 0; s <= gi; s++) begin
                    a_sr[s] <= '0;
                    b_sr[s] <= '0;
                end
            end else begin
                a_sr[0] <= accept ? a_col[gi*DW +: DW] : '0;
                b_sr[0] <= accept ? b_row[gi*DW +: DW] : '0;
                for (int s = 1; s <= gi; s++) begin
                    a_sr[s] <= a_sr[s-1];
                    b_sr[s] <= b_sr[s-1];
                end
            end
        end
        assign a_skew[gi] = a_sr[gi];
        assign b_skew[gi] = b_sr[gi];
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [DW-1:0] a_left;
            logic [DW-1:0] b_up;
            logic [DW-1:0] a_reg;
            logic [DW-1:0] b_reg;
            logic [AW-1:0] acc_reg;
            logic [AW-1:0] prod;

            if (gj == 0) begin : g_a_edge
                assign a_left = a_skew[gi];
            end else begin : g_a_inner
                assign a_left = a_pe[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_up = b_skew[gj];
            end else begin : g_b_inner
                assign b_up = b_pe[gi-1][gj];
            end

`ifdef SYSTOLIC_SIGNED_EN
            // Low AW bits of the sign-extended product are the exact signed result.
            assign prod = {{(AW-DW){a_reg[DW-1]}}, a_reg} * {{(AW-DW){b_reg[DW-1]}}, b_reg};
`else
            assign prod = {{(AW-DW){1'b0}}, a_reg} * {{(AW-DW){1'b0}}, b_reg};
`endif

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_reg   <= '0;
                    b_reg   <= '0;
                    acc_reg <= '0;
                end else begin
                    a_reg   <= a_left;
                    b_reg   <= b_up;
                    acc_reg <= start ? '0 : acc_reg + prod;
                end
            end

            assign a_pe[gi][gj] = a_reg;
            assign b_pe[gi][gj] = b_reg;
            assign acc[gi][gj]  = acc_reg;
        end
    end

    always_comb begin
        col_next = out_col + 1'b1;
        row_next = out_row;
        if (out_col == RW'(N-1)) begin
            col_next = '0;
            row_next = out_row + 1'b1;
        end
    end

    // Last product reaches PE(N-1,N-1) 2N edges after beat N-1; snapshot one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    out_buf[i][j] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= LOAD;
                        beat_cnt <= RW'(1);
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (beat_cnt == RW'(N-1)) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DCW'(2*N)) begin
                        for (int i = 0; i < N; i++)
                            for (int j = 0; j < N; j++)
                                out_buf[i][j] <= acc[i][j];
                        out_data  <= acc[0][0];
                        out_row   <= '0;
                        out_col   <= '0;
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            out_row   <= '0;
                            out_col   <= '0;
                            beat_cnt  <= '0;
                            busy      <= 1'b0;
                        end else begin
                            out_row  <= row_next;
                            out_col  <= col_next;
                            out_data <= out_buf[row_next][col_next];
                            out_last <= (row_next == RW'(N-1)) && (col_next == RW'(N-1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
